// File: rtl/wptr_burst_ctrl.sv
// Write-side pointer/level tracker for an async FIFO; all-or-nothing bursts of up to MAX_BURST entries per cycle.
// wack is combinational in the request cycle; pointers, level and flags register on the next wclk edge.
module wptr_burst_ctrl #(
   parameter  int ADDR_WIDTH = 4,
   parameter  int MAX_BURST  = 4,
   localparam int DEPTH      = 1 << ADDR_WIDTH,
   localparam int CW         = $clog2(MAX_BURST + 1),
   localparam int PW         = ADDR_WIDTH + 1
) (
   input  logic                  wclk,
   input  logic                  wrst,
   input  logic [CW-1:0]         wreq_cnt,
   input  logic [PW-1:0]         rptr_gray_sync,
   input  logic [PW-1:0]         afull_thresh,
   input  logic                  ovf_clr,
   output logic                  wack,
   output logic [ADDR_WIDTH-1:0] waddr,
   output logic [PW-1:0]         wptr,
   output logic [PW-1:0]         wptr_gray,
   output logic [PW-1:0]         wlevel,
   output logic                  wfull,
   output logic                  walmost_full,
   output logic                  woverflow
);

   localparam int SW = PW + 1;

   logic [PW-1:0] wbin_q, wbin_d;
   logic [PW-1:0] wptr_gray_q, wptr_gray_d;
   logic [PW-1:0] wlevel_q, wlevel_d;
   logic          wfull_q, wfull_d;
   logic          walmost_full_q, walmost_full_d;
   logic          woverflow_q, woverflow_d;

   logic [PW-1:0] rbin;
   logic [PW-1:0] level;
   logic [PW-1:0] level_next;
   logic [SW-1:0] fill_after;
   logic          req_vld;
   logic          cnt_legal;

   always_comb begin
      rbin = '0;
      for (int i = 0; i < PW; i++) begin
         rbin[i] = ^(rptr_gray_sync >> i);
      end
   end

   // level + cnt <= DEPTH is the space check; the extra bit keeps it from wrapping.
   assign level      = wbin_q - rbin;
   assign fill_after = SW'(level) + SW'(wreq_cnt);
   assign req_vld    = (wreq_cnt != '0);
   assign cnt_legal  = (wreq_cnt <= CW'(MAX_BURST));
   assign wack       = !wrst && req_vld && cnt_legal && (fill_after <= SW'(DEPTH));

   always_comb begin
      wbin_d      = wbin_q + (wack ? PW'(wreq_cnt) : '0);
      wptr_gray_d = wbin_d ^ (wbin_d >> 1);
      level_next  = wbin_d - rbin;
      wlevel_d    = level_next;
      wfull_d     = (level_next == PW'(DEPTH));
      if (afull_thresh == '0) begin
         walmost_full_d = 1'b1;
      end else if (afull_thresh > PW'(DEPTH)) begin
         walmost_full_d = 1'b0;
      end else begin
         walmost_full_d = (level_next >= afull_thresh);
      end
      // A new rejection outranks a clear in the same cycle.
      if (req_vld && !wack) begin
         woverflow_d = 1'b1;
      end else if (ovf_clr) begin
         woverflow_d = 1'b0;
      end else begin
         woverflow_d = woverflow_q;
      end
   end

   always_ff @(posedge wclk or posedge wrst) begin
      if (wrst) begin
         wbin_q         <= '0;
         wptr_gray_q    <= '0;
         wlevel_q       <= '0;
         wfull_q        <= 1'b0;
         walmost_full_q <= 1'b0;
         woverflow_q    <= 1'b0;
      end else begin
         wbin_q         <= wbin_d;
         wptr_gray_q    <= wptr_gray_d;
         wlevel_q       <= wlevel_d;
         wfull_q        <= wfull_d;
         walmost_full_q <= walmost_full_d;
         woverflow_q    <= woverflow_d;
      end
   end

   assign waddr        = wbin_q[ADDR_WIDTH-1:0];
   assign wptr         = wbin_q;
   assign wptr_gray    = wptr_gray_q;
   assign wlevel       = wlevel_q;
   assign wfull        = wfull_q;
   assign walmost_full = walmost_full_q;
   assign woverflow    = woverflow_q;

endmodule

// File: tb/tb_wptr_burst_ctrl.sv
// Bench for wptr_burst_ctrl (ADDR_WIDTH=4, MAX_BURST=4): directed scenarios plus random bursts against a counting model.
module tb_wptr_burst_ctrl;

   localparam int PW = 5;
   localparam int CW = 3;

   logic          wclk = 1'b0;
   logic          wrst = 1'b1;
   logic [CW-1:0] wreq_cnt = '0;
   logic [PW-1:0] rptr_gray_sync = '0;
   logic [PW-1:0] afull_thresh = 5'd12;
   logic          ovf_clr = 1'b0;
   logic          wack;
   logic [3:0]    waddr;
   logic [PW-1:0] wptr;
   logic [PW-1:0] wptr_gray;
   logic [PW-1:0] wlevel;
   logic          wfull;
   logic          walmost_full;
   logic          woverflow;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 wclk = ~wclk;

   wptr_burst_ctrl dut (
      .wclk           (wclk),
      .wrst           (wrst),
      .wreq_cnt       (wreq_cnt),
      .rptr_gray_sync (rptr_gray_sync),
      .afull_thresh   (afull_thresh),
      .ovf_clr        (ovf_clr),
      .wack           (wack),
      .waddr          (waddr),
      .wptr           (wptr),
      .wptr_gray      (wptr_gray),
      .wlevel         (wlevel),
      .wfull          (wfull),
      .walmost_full   (walmost_full),
      .woverflow      (woverflow)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   // ---------------- behavioural model: pointers as plain integers mod 32 ----------------
   function automatic int gray(input int b);
      return b ^ (b >> 1);
   endfunction

   function automatic int g2b(input int g);
      for (int b = 0; b < 32; b++) if (gray(b) == g) return b;
      return 0;
   endfunction

   function automatic int lvl(input int w, input int r);
      return (w - r + 32) % 32;
   endfunction

   function automatic bit m_accept(input int cnt, input int w, input int g, input bit rst);
      return !rst && cnt > 0 && cnt <= 4 && (lvl(w, g2b(g)) + cnt) <= 16;
   endfunction

   int m_wbin = 0, m_level = 0;
   bit m_full = 0, m_af = 0, m_ovf = 0;

   always @(posedge wclk or posedge wrst) begin : model
      int nw, nl;
      bit acc;
      if (wrst) begin
         m_wbin <= 0; m_level <= 0; m_full <= 0; m_af <= 0; m_ovf <= 0;
      end else begin
         acc = m_accept(int'(wreq_cnt), m_wbin, int'(rptr_gray_sync), 1'b0);
         nw  = acc ? (m_wbin + int'(wreq_cnt)) % 32 : m_wbin;
         nl  = lvl(nw, g2b(int'(rptr_gray_sync)));
         m_wbin  <= nw;
         m_level <= nl;
         m_full  <= (nl == 16);
         m_af    <= (afull_thresh == 0) ? 1'b1 : (afull_thresh > 16) ? 1'b0 : (nl >= int'(afull_thresh));
         if (wreq_cnt != 0 && !acc) m_ovf <= 1'b1;
         else if (ovf_clr)          m_ovf <= 1'b0;
      end
   end

   always @(negedge wclk) begin
      chk("wack",         wack,         m_accept(int'(wreq_cnt), m_wbin, int'(rptr_gray_sync), wrst));
      chk("wptr",         wptr,         m_wbin);
      chk("wptr_gray",    wptr_gray,    gray(m_wbin));
      chk("waddr",        waddr,        m_wbin % 16);
      chk("wlevel",       wlevel,       m_level);
      chk("wfull",        wfull,        m_full);
      chk("walmost_full", walmost_full, m_af);
      chk("woverflow",    woverflow,    m_ovf);
   end

   // ---------------- stimulus (all tasks entered at posedge+1) ----------------
   logic ack_seen;

   task automatic drive(input int cnt, input int rg, input bit clr);
      wreq_cnt       = CW'(cnt);
      rptr_gray_sync = PW'(rg);
      ovf_clr        = clr;
      #2 ack_seen = wack;
      @(posedge wclk); #1;
      wreq_cnt = '0;
      ovf_clr  = 1'b0;
   endtask

   task automatic do_reset();
      wrst = 1'b1; wreq_cnt = '0; rptr_gray_sync = '0; ovf_clr = 1'b0;
      @(posedge wclk); #1;
      wrst = 1'b0;
   endtask

   initial begin
      int r_rd, avail;
      repeat (2) @(posedge wclk);
      #1;
      chk("rst_wptr", wptr, 0);
      chk("rst_wlevel", wlevel, 0);
      chk("rst_woverflow", woverflow, 0);
      wrst = 1'b0;

      // Async reset mid-burst at wptr=7
      drive(4, 0, 0);
      drive(3, 0, 0);
      chk("pre_rst_wptr", wptr, 7);
      wreq_cnt = 3'd2;
      #2 wrst = 1'b1;
      #1;
      chk("async_wptr", wptr, 0);
      chk("async_wptr_gray", wptr_gray, 0);
      chk("async_wlevel", wlevel, 0);
      chk("async_wack", wack, 0);
      @(posedge wclk); #1;
      wrst = 1'b0;
      drive(2, 0, 0);
      chk("post_rst_wptr", wptr, 2);

      // Fill to full, then overflow
      do_reset();
      repeat (4) drive(4, 0, 0);
      chk("fill_wptr", wptr, 16);
      chk("fill_gray", wptr_gray, 5'b11000);
      chk("fill_wlevel", wlevel, 16);
      chk("fill_wfull", wfull, 1);
      drive(4, 0, 0);
      chk("fill5_wack", ack_seen, 0);
      chk("fill5_ovf", woverflow, 1);
      chk("fill5_wptr", wptr, 16);

      // Boundary at level 14
      do_reset();
      drive(4, 0, 0); drive(4, 0, 0); drive(4, 0, 0); drive(2, 0, 0);
      chk("bnd_level", wlevel, 14);
      drive(3, 0, 0);
      chk("bnd3_wack", ack_seen, 0);
      chk("bnd3_wptr", wptr, 14);
      chk("bnd3_ovf", woverflow, 1);
      drive(2, 0, 0);
      chk("bnd2_wack", ack_seen, 1);
      chk("bnd2_wfull", wfull, 1);
      drive(0, 0, 1);
      chk("bnd_clr_ovf", woverflow, 0);

      // Wrap past 31
      do_reset();
      for (int i = 0; i < 7; i++) drive(4, gray(i * 4), 0);
      drive(2, gray(28), 0);
      chk("wrap_pre_wptr", wptr, 30);
      drive(4, 5'b10001, 0);
      chk("wrap_wack", ack_seen, 1);
      chk("wrap_wptr", wptr, 2);
      chk("wrap_waddr", waddr, 2);
      chk("wrap_wlevel", wlevel, 4);
      chk("wrap_wfull", wfull, 0);

      // Almost-full threshold 12
      do_reset();
      afull_thresh = 5'd12;
      drive(4, 0, 0); drive(4, 0, 0);
      chk("af8_level", wlevel, 8);
      chk("af8_flag", walmost_full, 0);
      drive(4, 0, 0);
      chk("af12_flag", walmost_full, 1);
      drive(0, gray(1), 0);
      chk("af11_level", wlevel, 11);
      chk("af11_flag", walmost_full, 0);

      // Illegal count and set-beats-clear
      do_reset();
      drive(5, 0, 0);
      chk("ill_wack", ack_seen, 0);
      chk("ill_ovf", woverflow, 1);
      chk("ill_wptr", wptr, 0);
      drive(5, 0, 1);
      chk("ill_setclr_ovf", woverflow, 1);
      drive(0, 0, 1);
      chk("ill_clr_ovf", woverflow, 0);

      // Random bursts with a lagging reader
      do_reset();
      r_rd = 0;
      for (int k = 0; k < 2000; k++) begin
         if (k == 1000) begin
            do_reset();
            r_rd = 0;
         end
         if (k % 250 == 0) begin
            case ($urandom_range(0, 4))
               0:       afull_thresh = 5'd0;
               1:       afull_thresh = 5'd17;
               2:       afull_thresh = 5'd16;
               default: afull_thresh = PW'($urandom_range(1, 15));
            endcase
         end
         avail = lvl(m_wbin, r_rd);
         r_rd  = (r_rd + int'($urandom_range(0, avail))) % 32;
         drive(int'($urandom_range(0, 7)), gray(r_rd), $urandom_range(0, 7) == 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/wptr_burst_ctrl.md
WPTR_BURST_CTRL -- requirements
Module: wptr_burst_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, address width; FIFO depth DEPTH = 2^ADDR_WIDTH; legal range 2..12.
REQ-002 SHALL have parameter MAX_BURST, default 4, maximum writes accepted per cycle; legal range 1..DEPTH.
REQ-003 SHALL use CW = $clog2(MAX_BURST+1) as the width of the request count.
REQ-004 wclk  input  1  write-domain clock; the block has one clock, with all state on its rising edge.
REQ-005 wrst  input  1  reset, asynchronous and active-high.
REQ-006 wreq_cnt  input  CW  number of entries the writer requests to write this cycle (0 = idle).
REQ-007 rptr_gray_sync  input  ADDR_WIDTH+1  read pointer in Gray code, already synchronised into wclk.
REQ-008 afull_thresh  input  ADDR_WIDTH+1  almost-full level threshold, quasi-static.
REQ-009 ovf_clr  input  1  clears the sticky overflow flag.
REQ-010 wack  output  1  combinational; request accepted this cycle.
REQ-011 waddr  output  ADDR_WIDTH  first RAM address for this cycle's burst (wbin low bits).
REQ-012 wptr  output  ADDR_WIDTH+1  registered binary write pointer.
REQ-013 wptr_gray  output  ADDR_WIDTH+1  registered Gray write pointer, for crossing to the read domain.
REQ-014 wlevel  output  ADDR_WIDTH+1  registered fill level, 0..DEPTH.
REQ-015 wfull  output  1  registered; level == DEPTH.
REQ-016 walmost_full  output  1  registered; level >= afull_thresh.
REQ-017 woverflow  output  1  registered sticky; a request was rejected.

Function
REQ-018 SHALL convert rptr_gray_sync to binary rbin combinationally (XOR prefix from the MSB).
REQ-019 SHALL compute level = (wbin - rbin) mod 2^(ADDR_WIDTH+1) and space = DEPTH - level, both from the registered wbin.
REQ-020 SHALL assert wack iff 0 < wreq_cnt <= MAX_BURST and wreq_cnt <= space.
REQ-021 SHALL set wbin_next = wbin + (wack ? wreq_cnt : 0), modulo 2^(ADDR_WIDTH+1), with natural wrap.
REQ-022 SHALL reject a request all-or-nothing; partial acceptance is forbidden.
REQ-023 SHALL register on each edge: wptr <= wbin_next and wptr_gray <= wbin_next ^ (wbin_next >> 1).
REQ-024 SHALL register wlevel, wfull and walmost_full from level_next = wbin_next - rbin, so they reflect the accepted burst one cycle later.
REQ-025 Stale rptr_gray_sync SHALL only make level pessimistic; the block SHALL never accept into occupied entries.
REQ-026 SHALL set woverflow on the next edge when wreq_cnt != 0 and wack == 0, covering both wreq_cnt > space and wreq_cnt > MAX_BURST.
REQ-027 SHALL clear woverflow on an edge with ovf_clr = 1; if set and clear coincide, set wins.
REQ-028 SHALL treat afull_thresh = 0 as walmost_full always 1, and afull_thresh > DEPTH as walmost_full always 0.
REQ-029 wreq_cnt = 0 SHALL leave all pointers unchanged and SHALL NOT affect woverflow.
REQ-030 waddr SHALL equal wbin[ADDR_WIDTH-1:0]; the writer fills addresses waddr .. waddr+wreq_cnt-1 mod DEPTH when wack = 1.

Reset
REQ-031 While wrst = 1, SHALL asynchronously force wbin, wptr, wptr_gray and wlevel to 0, and wfull, walmost_full and woverflow to 0.
REQ-032 SHALL allow deassertion of wrst on any edge; the first accept is possible on the first rising edge after deassertion.
REQ-033 wack SHALL be 0 while wrst = 1, regardless of wreq_cnt.

Verification (ADDR_WIDTH=4, MAX_BURST=4, DEPTH=16)
REQ-034 Reset: assert wrst mid-burst at wptr=7 -> outputs 0 immediately, without waiting for wclk; after release, wreq_cnt=2 -> wptr=2.
REQ-035 Fill: rptr_gray_sync=0, wreq_cnt=4 for 4 cycles -> wptr=16, wptr_gray=5'b11000, wlevel=16, wfull=1; a 5th request -> wack=0, woverflow=1.
REQ-036 Boundary: level 14, wreq_cnt=3 -> wack=0, wptr unchanged, woverflow=1; then wreq_cnt=2 -> wack=1, wfull=1; ovf_clr=1 -> woverflow=0.
REQ-037 Wrap: rbin=30 (Gray 5'b10001), wbin=30, wreq_cnt=4 -> wptr=2, waddr=2, wlevel=4, wfull=0.
REQ-038 Almost-full: afull_thresh=12, level 8, wreq_cnt=4 -> walmost_full=1 next cycle; advance rbin by 1 -> walmost_full=0.
REQ-039 Illegal count: wreq_cnt=5 (>MAX_BURST) with level 0 -> wack=0, woverflow=1; ovf_clr together with a new overflow -> woverflow stays 1.
